// File: rtl/tx_arbiter.sv
// Round-robin arbiter that frames one requester word per packet
// (0xAA, code, data, 0x55) and writes it bytewise into the TX FIFO.
module tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TX_FIFO_LOAD_W = 12,
    parameter int unsigned TX_FIFO_DEPTH  = 2048
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [16*NUM_REQ-1:0]       req_code,
    input  logic [32*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [TX_FIFO_LOAD_W-1:0]   txfifo_load,
    input  logic                        txfifo_full,
    output logic                        txfifo_wr,
    output logic [7:0]                  txfifo_data,
    output logic                        busy,
    output logic [15:0]                 frames_sent
);

    localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LVL_W      = TX_FIFO_LOAD_W + 1;
    localparam int unsigned FRAME_W    = 64;
    localparam int unsigned FRAME_LEN  = 8;
    // Highest occupancy that still leaves space for a whole frame.
    localparam logic [LVL_W-1:0] ROOM_LIMIT = LVL_W'(TX_FIFO_DEPTH - FRAME_LEN);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [15:0]          frames_sent_q, frames_sent_d;

    logic                 room;
    logic                 gnt_found;
    logic [NUM_REQ-1:0]   gnt_oh;
    logic [IDX_W-1:0]     gnt_idx;
    logic [15:0]          gnt_code;
    logic [31:0]          gnt_data;
    logic [FRAME_W-1:0]   frame_shift;

    // Widened compare so an occupancy above the depth reads as "no room".
    assign room = ({1'b0, txfifo_load} <= ROOM_LIMIT);

    // Pick the first valid requester searching upward from last_grant+1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_oh    = '0;
        gnt_idx   = '0;
        gnt_code  = '0;
        gnt_data  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!gnt_found && req_valid[i] &&
                    (i == ((32'(last_grant_q) + k) % NUM_REQ))) begin
                    gnt_found = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_idx   = IDX_W'(i);
                    gnt_code  = req_code[16*i +: 16];
                    gnt_data  = req_data[32*i +: 32];
                end
            end
        end
    end

    // Next-state and strobe logic; reset forces all strobes low.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        last_grant_d  = last_grant_q;
        frame_d       = frame_q;
        frames_sent_d = frames_sent_q;
        req_ready     = '0;
        txfifo_wr     = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (room && gnt_found) begin
                        req_ready    = gnt_oh;
                        last_grant_d = gnt_idx;
                        frame_d      = {8'hAA, gnt_code, gnt_data, 8'h55};
                        byte_idx_d   = 3'd0;
                        state_d      = S_SEND;
                    end
                end
                S_SEND: begin
                    if (!txfifo_full) begin
                        txfifo_wr  = 1'b1;
                        byte_idx_d = byte_idx_q + 3'd1;
                        if (byte_idx_q == 3'd7) begin
                            frames_sent_d = frames_sent_q + 16'd1;
                            state_d       = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Byte 0 sits in the top of the frame register.
    always_comb begin
        frame_shift = frame_q << {byte_idx_q, 3'b000};
        txfifo_data = frame_shift[FRAME_W-1 -: 8];
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            byte_idx_q    <= 3'd0;
            last_grant_q  <= IDX_W'(NUM_REQ - 1);
            frame_q       <= '0;
            frames_sent_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            last_grant_q  <= last_grant_d;
            frame_q       <= frame_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign busy        = (state_q == S_SEND);
    assign frames_sent = frames_sent_q;

endmodule
